// File: rtl/bank_host.sv
// bank_host: UART 8N1 host for a percept bank; sends addr/op/data frames and, when op[7] is set, receives one reply byte.
// Optional response timeout is compiled in with `define BANK_HOST_TIMEOUT_EN.

module bank_host #(
    parameter int CLK_DIV = 434,
    parameter int TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic       tx,
    input  logic       rx
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

    if (CLK_DIV < 4 || TIMEOUT < 1) begin : g_param_check
        $error("bank_host: CLK_DIV must be >= 4 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT, S_RX, S_DONE} state_t;

    state_t        state_q;
    logic          cmd_ready_q;
    logic          tx_q;
    logic          rsp_valid_q;
    logic [7:0]    rsp_data_q;
    logic [7:0]    rx_sh_q;
    logic [28:0]   tx_sh_q;
    logic [4:0]    bit_cnt_q;
    logic [CW-1:0] clk_cnt_q;
    logic          rx_meta_q;
    logic          rx_sync_q;
    logic          expect_q;

`ifdef BANK_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] to_cnt_q;
    logic          to_flag_q;
    logic          rsp_timeout_q;
`endif

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            tx_q        <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= '1;
            bit_cnt_q   <= '0;
            clk_cnt_q   <= '0;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            expect_q    <= 1'b0;
`ifdef BANK_HOST_TIMEOUT_EN
            to_cnt_q      <= '0;
            to_flag_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        // start bit of the addr frame goes out now; the remaining 29 bits are queued LSB first
                        tx_sh_q     <= {1'b1, cmd_data, 1'b0, 1'b1, cmd_op, 1'b0, 1'b1, cmd_addr};
                        tx_q        <= 1'b0;
                        expect_q    <= cmd_op[7];
                        clk_cnt_q   <= '0;
                        bit_cnt_q   <= '0;
                        cmd_ready_q <= 1'b0;
                        state_q     <= S_TX;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                S_TX: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        if (bit_cnt_q == 5'd29) begin
                            state_q <= expect_q ? S_WAIT : S_DONE;
`ifdef BANK_HOST_TIMEOUT_EN
                            to_cnt_q  <= '0;
                            to_flag_q <= 1'b0;
`endif
                        end else begin
                            tx_q      <= tx_sh_q[0];
                            tx_sh_q   <= {1'b1, tx_sh_q[28:1]};
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (!rx_sync_q) begin
                        clk_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= S_RX;
                    end
`ifdef BANK_HOST_TIMEOUT_EN
                    else if (to_cnt_q == TO_LAST) begin
                        to_flag_q  <= 1'b1;
                        rsp_data_q <= '0;
                        state_q    <= S_DONE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TW'(1);
                    end
`endif
                end
                S_RX: begin
                    if (bit_cnt_q == 5'd0) begin
                        // mid-start re-check; a high line means a glitch, resume waiting without touching the timeout
                        if (clk_cnt_q == HALF_LAST) begin
                            clk_cnt_q <= '0;
                            if (rx_sync_q) state_q <= S_WAIT;
                            else           bit_cnt_q <= 5'd1;
                        end else begin
                            clk_cnt_q <= clk_cnt_q + CW'(1);
                        end
                    end else if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        if (bit_cnt_q == 5'd9) begin
                            rsp_data_q <= rx_sh_q;
                            state_q    <= S_DONE;
                        end else begin
                            rx_sh_q   <= {rx_sync_q, rx_sh_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    rsp_valid_q <= 1'b1;
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
`ifdef BANK_HOST_TIMEOUT_EN
                    rsp_timeout_q <= to_flag_q;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign tx        = tx_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
`ifdef BANK_HOST_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule
